// File: rtl/brick_grid_sequencer.sv
// Brick-grid scan sequencer: walks an 8x6 brick grid and hands each live or dirty brick
// to a downstream draw stage. It also tracks which bricks are still alive after collision hits.
module brick_grid_sequencer #(
    parameter logic [7:0] X_OFFSET = 8'd16,
    parameter logic [6:0] Y_OFFSET = 7'd8
) (
    input  logic       clock,
    input  logic       reset_state,
    input  logic       start,
    input  logic       load_level,
    input  logic       hit_valid,
    input  logic [2:0] hit_col,
    input  logic [2:0] hit_row,
    input  logic       draw_done,
    output logic       draw_enable,
    output logic [7:0] brick_x,
    output logic [6:0] brick_y,
    output logic [2:0] brick_colour,
    output logic       busy,
    output logic       frame_done,
    output logic [5:0] bricks_left,
    output logic       all_cleared
);

    typedef enum logic [2:0] {IDLE, CHECK, DRAW, NEXT, FINISH} state_t;

    state_t      state, state_next;
    logic [47:0] alive, dirty;
    logic [2:0]  col, row;
    logic [5:0]  idx, hit_idx;
    logic        hit_ok;

    // row*8 + col is just the concatenation of the two 3-bit counters
    assign idx     = {row, col};
    assign hit_idx = {hit_row, hit_col};
    assign hit_ok  = hit_valid && (hit_row <= 3'd5) && alive[hit_idx];

    assign brick_x     = X_OFFSET + {1'b0, col, 4'b0000};
    assign brick_y     = Y_OFFSET + {2'b00, row, 2'b00};
    assign busy        = (state != IDLE);
    assign draw_enable = (state == DRAW);
    assign frame_done  = (state == FINISH);
    assign all_cleared = (bricks_left == 6'd0);

    always_comb begin
        brick_colour = 3'b000;
        if (alive[idx]) begin
            case (row)
                3'd0:    brick_colour = 3'b100;
                3'd1:    brick_colour = 3'b110;
                3'd2:    brick_colour = 3'b010;
                3'd3:    brick_colour = 3'b011;
                3'd4:    brick_colour = 3'b001;
                3'd5:    brick_colour = 3'b101;
                default: brick_colour = 3'b000;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = (alive[idx] || dirty[idx]) ? DRAW : NEXT;
            DRAW:    if (draw_done) state_next = NEXT;
            NEXT:    state_next = (idx == 6'd47) ? FINISH : CHECK;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_state) begin
            state       <= IDLE;
            alive       <= '0;
            dirty       <= '0;
            col         <= '0;
            row         <= '0;
            bricks_left <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end
            if (state == NEXT && idx != 6'd47) begin
                if (col == 3'd7) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
            if (state == IDLE && load_level) begin
                alive       <= '1;
                dirty       <= '0;
                bricks_left <= 6'd48;
            end else begin
                if (state == DRAW && draw_done)
                    dirty[idx] <= 1'b0;
                // Later assignment wins: a hit landing with draw_done keeps the brick dirty
                if (hit_ok) begin
                    alive[hit_idx] <= 1'b0;
                    dirty[hit_idx] <= 1'b1;
                    if (bricks_left != 6'd0)
                        bricks_left <= bricks_left - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_grid_sequencer.sv
// Directed bench for brick_grid_sequencer: a table of single-cycle vectors in IDLE,
// followed by hand-written multi-cycle scan scenarios.
module tb_brick_grid_sequencer;

    logic       clock = 1'b0;
    logic       reset_state, start, load_level, hit_valid, draw_done;
    logic [2:0] hit_col, hit_row;
    logic       draw_enable, busy, frame_done, all_cleared;
    logic [7:0] brick_x;
    logic [6:0] brick_y;
    logic [2:0] brick_colour;
    logic [5:0] bricks_left;

    int checks   = 0;
    int failures = 0;

    brick_grid_sequencer #(.X_OFFSET(8'd16), .Y_OFFSET(7'd8)) dut (
        .clock(clock), .reset_state(reset_state), .start(start), .load_level(load_level),
        .hit_valid(hit_valid), .hit_col(hit_col), .hit_row(hit_row), .draw_done(draw_done),
        .draw_enable(draw_enable), .brick_x(brick_x), .brick_y(brick_y),
        .brick_colour(brick_colour), .busy(busy), .frame_done(frame_done),
        .bricks_left(bricks_left), .all_cleared(all_cleared)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n, st, ld, hv;
        logic [2:0] hc, hr;
        logic       e_busy, e_de, e_fd, e_clr;
        logic [5:0] e_left;
        logic [2:0] e_col;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hit(input int c, input int r);
        hit_valid = 1'b1;
        hit_col   = 3'(c);
        hit_row   = 3'(r);
        tick();
        hit_valid = 1'b0;
    endtask

    // Runs one scan: draw_done is returned on the third cycle after each draw_enable rise.
    task automatic run_scan(input bit guard, input int coll_visit, input int probe,
                            output int visits, output int frames,
                            output int fx, output int fy, output int fc,
                            output int lx, output int ly, output int lc, output int pc);
        int  cnt;
        bit  prev_de, done;
        visits = 0; frames = 0; fx = -1; fy = -1; fc = -1;
        lx = -1; ly = -1; lc = -1; pc = -1;
        cnt = 0; prev_de = 1'b0; done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            start = 1'b0; load_level = 1'b0; hit_valid = 1'b0; draw_done = 1'b0;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (frame_done) frames++;
            if (draw_enable && !prev_de) begin
                if (visits == 0) begin
                    fx = int'(brick_x); fy = int'(brick_y); fc = int'(brick_colour);
                end
                lx = int'(brick_x); ly = int'(brick_y); lc = int'(brick_colour);
                if (visits == probe) pc = int'(brick_colour);
                if (guard && visits == 5) begin
                    start = 1'b1;
                    load_level = 1'b1;
                end
                visits++;
                cnt = 1;
            end else if (draw_enable) begin
                cnt++;
            end
            if (draw_enable && cnt == 3) begin
                draw_done = 1'b1;
                if (visits - 1 == coll_visit) begin
                    hit_valid = 1'b1;
                    hit_col   = 3'((int'(brick_x) - 16) / 16);
                    hit_row   = 3'((int'(brick_y) - 8) / 4);
                end
            end
            prev_de = draw_enable;
            tick();
        end
        draw_done = 1'b0; hit_valid = 1'b0; start = 1'b0; load_level = 1'b0;
        chk("scan_terminates", int'(done), 1);
    endtask

    int v, f, fx, fy, fc, lx, ly, lc, pc;

    initial begin
        reset_state = 1'b0; start = 1'b0; load_level = 1'b0; hit_valid = 1'b0;
        draw_done = 1'b0; hit_col = '0; hit_row = '0;

        //         rst st ld hv hc    hr    busy de fd clr left   colour
        vecs[0]  = '{0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 6'd0,  3'b000};
        vecs[1]  = '{1, 0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 6'd48, 3'b100};
        vecs[2]  = '{1, 0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, 6'd47, 3'b000};
        vecs[3]  = '{1, 0, 0, 1, 3'd0, 3'd0, 0, 0, 0, 0, 6'd47, 3'b000};
        vecs[4]  = '{1, 0, 0, 1, 3'd0, 3'd6, 0, 0, 0, 0, 6'd47, 3'b000};
        vecs[5]  = '{1, 0, 0, 1, 3'd7, 3'd5, 0, 0, 0, 0, 6'd46, 3'b000};
        vecs[6]  = '{1, 0, 0, 1, 3'd3, 3'd7, 0, 0, 0, 0, 6'd46, 3'b000};
        vecs[7]  = '{1, 0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 6'd48, 3'b100};
        vecs[8]  = '{1, 0, 0, 1, 3'd3, 3'd2, 0, 0, 0, 0, 6'd47, 3'b100};
        vecs[9]  = '{0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 6'd0,  3'b000};
        vecs[10] = '{1, 0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 0, 6'd48, 3'b100};

        for (int i = 0; i < 11; i++) begin
            reset_state = vecs[i].rst_n; start = vecs[i].st; load_level = vecs[i].ld;
            hit_valid = vecs[i].hv; hit_col = vecs[i].hc; hit_row = vecs[i].hr;
            tick();
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_draw_enable", i), int'(draw_enable), int'(vecs[i].e_de));
            chk($sformatf("vec%0d_frame_done", i), int'(frame_done), int'(vecs[i].e_fd));
            chk($sformatf("vec%0d_all_cleared", i), int'(all_cleared), int'(vecs[i].e_clr));
            chk($sformatf("vec%0d_bricks_left", i), int'(bricks_left), int'(vecs[i].e_left));
            chk($sformatf("vec%0d_colour", i), int'(brick_colour), int'(vecs[i].e_col));
        end
        start = 1'b0; load_level = 1'b0; hit_valid = 1'b0;
        chk("idle_brick_x", int'(brick_x), 16);
        chk("idle_brick_y", int'(brick_y), 8);

        // Full draw of a freshly loaded level
        reset_state = 1'b0; tick(); reset_state = 1'b1;
        load_level = 1'b1; tick(); load_level = 1'b0;
        run_scan(0, -1, -1, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("full_visits", v, 48);
        chk("full_frames", f, 1);
        chk("full_first_x", fx, 16);
        chk("full_first_y", fy, 8);
        chk("full_first_colour", fc, 3'b100);
        chk("full_last_x", lx, 128);
        chk("full_last_y", ly, 28);
        chk("full_last_colour", lc, 3'b101);

        // Two hit bricks are redrawn dead, then skipped
        hit(0, 0);
        hit(7, 5);
        chk("skip_left_after_hits", int'(bricks_left), 46);
        run_scan(0, -1, -1, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("skip_dirty_visits", v, 48);
        chk("skip_first_colour", fc, 0);
        chk("skip_last_colour", lc, 0);
        run_scan(0, -1, -1, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("skip_visits", v, 46);
        chk("skip_first_x", fx, 32);
        chk("skip_last_x", lx, 112);
        chk("skip_last_colour2", lc, 3'b101);
        chk("skip_left", int'(bricks_left), 46);

        // start/load_level pulsed mid-scan are ignored
        run_scan(1, -1, -1, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("guard_visits", v, 46);
        chk("guard_frames", f, 1);
        chk("guard_left", int'(bricks_left), 46);

        // Hit arriving together with draw_done keeps the brick dirty
        load_level = 1'b1; tick(); load_level = 1'b0;
        run_scan(0, 2, -1, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("coll_visits", v, 48);
        chk("coll_left", int'(bricks_left), 47);
        run_scan(0, -1, 2, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("coll_redraw_visits", v, 48);
        chk("coll_redraw_colour", pc, 0);
        run_scan(0, -1, -1, v, f, fx, fy, fc, lx, ly, lc, pc);
        chk("coll_after_visits", v, 47);

        // Hit on the brick being drawn turns its colour dead on the next cycle
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 20 && !draw_enable; i++) tick();
        chk("middraw_enable", int'(draw_enable), 1);
        chk("middraw_colour_before", int'(brick_colour), 3'b100);
        hit(0, 0);
        chk("middraw_colour_after", int'(brick_colour), 0);
        chk("middraw_still_drawing", int'(draw_enable), 1);

        // Reset while DRAW is active
        reset_state = 1'b0; tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_draw_enable", int'(draw_enable), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_left", int'(bricks_left), 0);
        chk("rst_all_cleared", int'(all_cleared), 1);
        reset_state = 1'b1; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
